// File: rtl/sqrt_controller.sv
// sqrt_controller: control FSM sequencing the 8-bit sqrt(i1^2+i2^2) ~ max(0.875x+0.5y, x) datapath
// Ports: clk, rst (sync, active-high), start;
//        en_R1..en_R5 register enables; b1/b6 single-source bus drivers;
//        b2,b3,b4,b5,b7 two-source bus drivers (bit1 first source, bit0 second);
//        sel_AU1/sel_AU2 AU function selects; Done result-driver enable; busy LOAD..WR_RES.
module sqrt_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       en_R1,
    output logic       en_R2,
    output logic       en_R3,
    output logic       en_R4,
    output logic       en_R5,
    output logic       b1,
    output logic       b6,
    output logic [1:0] b2,
    output logic [1:0] b3,
    output logic [1:0] b4,
    output logic [1:0] b5,
    output logic [1:0] b7,
    output logic [1:0] sel_AU1,
    output logic [1:0] sel_AU2,
    output logic       Done,
    output logic       busy
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_ABS_X, S_ABS_Y, S_WR_Y, S_MAX, S_MIN,
        S_SUB, S_WR_T5, S_ADD, S_WR_T7, S_FMAX, S_WR_RES, S_DONE
    } state_t;
    typedef struct packed {
        logic       en1, en2, en3, en4, en5, b1, b6;
        logic [1:0] b2, b3, b4, b5, b7, s1, s2;
        logic       done, busy;
    } ctl_t;
    state_t state, nxt;
    ctl_t   c, q;
    // Encoding is sequential, so every busy state simply advances by one.
    always_comb begin
        nxt = (state == S_IDLE || state == S_DONE) ? (start ? S_LOAD : state) : state_t'(state + 4'd1);
        c = '0;
        c.busy = nxt != S_IDLE && nxt != S_DONE;
        case (nxt)
            S_LOAD:   begin c.b3 = 2'b10; c.b4 = 2'b10; c.en1 = 1'b1; c.en2 = 1'b1; end
            S_ABS_X:  begin c.b1 = 1'b1; c.b2 = 2'b01; c.s1 = 2'b00; end
            S_ABS_Y:  begin c.b1 = 1'b1; c.b2 = 2'b01; c.s1 = 2'b01; c.b3 = 2'b01; c.en1 = 1'b1; end
            S_WR_Y:   begin c.b4 = 2'b01; c.en2 = 1'b1; end
            S_MAX:    begin c.b1 = 1'b1; c.b2 = 2'b01; c.s1 = 2'b10; end
            S_MIN:    begin c.b1 = 1'b1; c.b2 = 2'b01; c.s1 = 2'b11; c.en4 = 1'b1; c.b7 = 2'b10; c.en3 = 1'b1; end
            S_SUB:    begin c.en5 = 1'b1; c.b5 = 2'b10; c.b6 = 1'b1; c.s2 = 2'b10; end
            S_WR_T5:  begin c.b7 = 2'b01; c.en3 = 1'b1; end
            S_ADD:    begin c.b5 = 2'b01; c.b6 = 1'b1; c.s2 = 2'b00; end
            S_WR_T7:  begin c.b7 = 2'b01; c.en3 = 1'b1; end
            S_FMAX:   begin c.b5 = 2'b10; c.b6 = 1'b1; c.s2 = 2'b01; end
            S_WR_RES: begin c.b7 = 2'b01; c.en3 = 1'b1; end
            S_DONE:   c.done = 1'b1;
            default:  c = '0;
        endcase
    end
    // Outputs are registered alongside the state so each is a pure decode of the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            q     <= '0;
        end else begin
            state <= nxt;
            q     <= c;
        end
    end
    assign {en_R1, en_R2, en_R3, en_R4, en_R5} = {q.en1, q.en2, q.en3, q.en4, q.en5};
    assign {b1, b6, b2, b3, b4, b5, b7} = {q.b1, q.b6, q.b2, q.b3, q.b4, q.b5, q.b7};
    assign sel_AU1 = q.s1;
    assign sel_AU2 = q.s2;
    assign Done    = q.done;
    assign busy    = q.busy;
endmodule

// File: doc/sqrt_controller.md
Name: sqrt_controller

Overview:
- Control FSM that sequences the 8-bit square-root-approximation datapath.
- Computes sqrt(i1^2 + i2^2) ≈ max(0.875·x + 0.5·y, x), where x = max(|i1|, |i2|) and y = min(|i1|, |i2|).
- Drives every register enable, tri-state bus enable, AU function select and the Done strobe of the datapath.
- Sits beside the datapath in the top level; receives start from the environment.

Parameters:
- none. The schedule is fixed for a single-cycle AU result latency: operands are on the buses in cycle k, and the result is on AU1_out/AU2_out in cycle k+1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a computation; sampled in IDLE and DONE
- en_R1, en_R2, en_R3, en_R4, en_R5  output  1 each  datapath register enables
- b1, b6  output  1 each  bus1 (R1) and bus6 (R3) drivers
- b2, b3, b4, b5, b7  output  2 each  two-source bus drivers; bit1 = first source, bit0 = second source
- sel_AU1  output  2  00 = |A|, 01 = |B|, 10 = max(A,B), 11 = min(A,B)
- sel_AU2  output  2  00 = A+B, 01 = max(A,B), 10 = A−B
- Done  output  1  enables the result driver
- busy  output  1  high from LOAD through WR_RES

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Fully Moore. Every output is a registered-state decode.
- Any output not listed for a state is 0.
- On rst: state = IDLE, all outputs 0.
- rst mid-operation aborts to IDLE on the next edge; no register enable fires in that cycle's decode after reset.
- Inputs i1/i2 are 8-bit two's complement; the result is unsigned 8-bit. The datapath wraps mod 256; the controller does no arithmetic.
- State sequence, one cycle each unless noted:
  - IDLE: wait. start=1 -> LOAD.
  - LOAD: b3=10, b4=10, en_R1, en_R2 (R1 <= i1, R2 <= i2). busy=1.
  - ABS_X: b1=1, b2=01, sel_AU1=00.
  - ABS_Y: b1=1, b2=01, sel_AU1=01; b3=01, en_R1 (R1 <= |i1|).
  - WR_Y: b4=01, en_R2 (R2 <= |i2|). This is a hazard bubble: max must see the new R2.
  - MAX: b1=1, b2=01, sel_AU1=10.
  - MIN: b1=1, b2=01, sel_AU1=11; en_R4 (R4 <= x); b7=10, en_R3 (R3 <= x>>3).
  - SUB: en_R5 (R5 <= y>>1); b5=10, b6=1, sel_AU2=10.
  - WR_T5: b7=01, en_R3 (R3 <= x − x>>3).
  - ADD: b5=01, b6=1, sel_AU2=00.
  - WR_T7: b7=01, en_R3.
  - FMAX: b5=10, b6=1, sel_AU2=01.
  - WR_RES: b7=01, en_R3 (R3 <= result).
  - DONE: Done=1, busy=0.
    - start=0: stay in DONE; the result stays driven.
    - start=1: go to LOAD (back-to-back operation).
- Timing: start sampled at edge 0 -> LOAD in cycle 1 -> DONE (Done=1) in cycle 13.
- start is ignored while busy. Holding start high from DONE restarts immediately.
- Invariant: no 2-bit bus enable is ever 11 (bus contention). The bench asserts this every cycle.
- Done and busy are never high together.

Test Plan:
- rst held 3 cycles, then released with start=0 -> all outputs 0, state remains IDLE, Done=0 for 20 cycles.
- i1=3, i2=4, 1-cycle start pulse -> busy cycles 1–12; Done=1 from cycle 13; result=5. Intermediate checks: R4=4, R5=1, R3 sequence 0, 4, 5, 5.
- i1=8'hFA (−6), i2=8 -> x=8, y=6, t5=7, t7=10; result=10. Also i1=100, i2=0 -> t7=88, final max selects 100.
- i1=0, i2=0 -> result=0. Then start held high continuously -> DONE lasts exactly 1 cycle, then LOAD; the second result is also correct.
- rst asserted in SUB during a run (i1=3, i2=4) -> IDLE on next edge, all outputs 0. A new start then yields 5 with Done at cycle 13.
- start toggled randomly during busy -> no effect on sequence or timing. Assertion checks every cycle: no bus-enable 11, and Done&busy=0.
